// File: rtl/vec_issue_resp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vec_issue_resp_ctrl
// Description : Val/ready controller between the scalar core and the vector
//               datapath. Buffers instructions in an IQ, issues one at a time,
//               queues results (or watchdog timeout errors) in an RQ.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_issue_resp_ctrl #(
  parameter int INST_W   = 32,
  parameter int DATA_W   = 32,
  parameter int IQ_DEPTH = 4,
  parameter int RQ_DEPTH = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_inst_valid,
  input  logic [INST_W-1:0]             i_inst_data,
  output logic                          o_inst_ready,
  output logic                          o_dp_issue_valid,
  output logic [INST_W-1:0]             o_dp_issue_inst,
  input  logic                          i_dp_issue_ready,
  input  logic                          i_dp_done,
  input  logic [DATA_W-1:0]             i_dp_result,
  output logic                          o_resp_valid,
  output logic [DATA_W-1:0]             o_resp_data,
  output logic                          o_resp_err,
  input  logic                          i_resp_ready,
  output logic                          o_busy,
  output logic [$clog2(IQ_DEPTH+1)-1:0] o_iq_count
);

  localparam int c_iq_pw = $clog2(IQ_DEPTH);
  localparam int c_iq_cw = $clog2(IQ_DEPTH + 1);
  localparam int c_rq_pw = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
  localparam int c_rq_cw = $clog2(RQ_DEPTH + 1);
  localparam int c_tm_w  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_tm_w-1:0] c_tmo_last = (TIMEOUT != 0) ? c_tm_w'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [INST_W-1:0]  r_iq_mem [IQ_DEPTH];
  logic [c_iq_pw-1:0] r_iq_wptr, r_iq_rptr;
  logic [c_iq_cw-1:0] r_iq_cnt;
  logic [DATA_W-1:0]  r_rq_data [RQ_DEPTH];
  logic               r_rq_err  [RQ_DEPTH];
  logic [c_rq_pw-1:0] r_rq_wptr, r_rq_rptr;
  logic [c_rq_cw-1:0] r_rq_cnt;
  logic [c_tm_w-1:0]  r_timer;

  logic w_iq_full, w_iq_empty, w_iq_push, w_iq_pop, w_iq_avail;
  logic w_rq_full, w_rq_empty, w_rq_push, w_rq_pop, w_rq_full_if_push;
  logic w_tmo_hit;

  assign w_iq_full  = (r_iq_cnt == c_iq_cw'(IQ_DEPTH));
  assign w_iq_empty = (r_iq_cnt == '0);
  // Full is judged on the registered count, so a same-cycle pop never frees room
  assign w_iq_push  = i_inst_valid && !w_iq_full;
  // An entry being written this cycle is readable at the next edge, so it may be issued
  assign w_iq_avail = !w_iq_empty || w_iq_push;

  assign w_rq_full  = (r_rq_cnt == c_rq_cw'(RQ_DEPTH));
  assign w_rq_empty = (r_rq_cnt == '0);
  assign w_rq_pop   = !w_rq_empty && i_resp_ready;
  // Count after an EXEC push reaches depth only if nothing drains this cycle
  assign w_rq_full_if_push = !w_rq_pop && (r_rq_cnt == c_rq_cw'(RQ_DEPTH - 1));

  assign w_tmo_hit  = (TIMEOUT != 0) && (r_timer == c_tmo_last);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic plus queue pop/push strobes owned by the FSM
  always_comb begin
    w_state_nxt = r_state;
    w_iq_pop    = 1'b0;
    w_rq_push   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_iq_avail && !w_rq_full) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (i_dp_issue_ready) begin
          w_iq_pop    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (i_dp_done || w_tmo_hit) begin
          w_rq_push   = 1'b1;
          w_state_nxt = (w_iq_avail && !w_rq_full_if_push) ? S_ISSUE : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Watchdog: cleared on issue handshake, counts every EXEC cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 r_timer <= '0;
    else if (w_iq_pop)          r_timer <= '0;
    else if (r_state == S_EXEC) r_timer <= r_timer + 1'b1;
  end

  // Instruction queue storage (contents need no reset; validity is tracked by count)
  always_ff @(posedge clk) begin
    if (w_iq_push) r_iq_mem[r_iq_wptr] <= i_inst_data;
  end

  // Instruction queue pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_iq_wptr <= '0;
      r_iq_rptr <= '0;
      r_iq_cnt  <= '0;
    end else begin
      if (w_iq_push)
        r_iq_wptr <= (r_iq_wptr == c_iq_pw'(IQ_DEPTH - 1)) ? '0 : r_iq_wptr + 1'b1;
      if (w_iq_pop)
        r_iq_rptr <= (r_iq_rptr == c_iq_pw'(IQ_DEPTH - 1)) ? '0 : r_iq_rptr + 1'b1;
      case ({w_iq_push, w_iq_pop})
        2'b10:   r_iq_cnt <= r_iq_cnt + 1'b1;
        2'b01:   r_iq_cnt <= r_iq_cnt - 1'b1;
        default: r_iq_cnt <= r_iq_cnt;
      endcase
    end
  end

  // Response queue storage; dp_done takes priority over a coincident timeout
  always_ff @(posedge clk) begin
    if (w_rq_push) begin
      r_rq_data[r_rq_wptr] <= i_dp_done ? i_dp_result : '0;
      r_rq_err[r_rq_wptr]  <= !i_dp_done;
    end
  end

  // Response queue pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rq_wptr <= '0;
      r_rq_rptr <= '0;
      r_rq_cnt  <= '0;
    end else begin
      if (w_rq_push)
        r_rq_wptr <= (r_rq_wptr == c_rq_pw'(RQ_DEPTH - 1)) ? '0 : r_rq_wptr + 1'b1;
      if (w_rq_pop)
        r_rq_rptr <= (r_rq_rptr == c_rq_pw'(RQ_DEPTH - 1)) ? '0 : r_rq_rptr + 1'b1;
      case ({w_rq_push, w_rq_pop})
        2'b10:   r_rq_cnt <= r_rq_cnt + 1'b1;
        2'b01:   r_rq_cnt <= r_rq_cnt - 1'b1;
        default: r_rq_cnt <= r_rq_cnt;
      endcase
    end
  end

  // Data outputs are gated so they read zero whenever their valid is low
  assign o_inst_ready     = !w_iq_full;
  assign o_dp_issue_valid = (r_state == S_ISSUE);
  assign o_dp_issue_inst  = o_dp_issue_valid ? r_iq_mem[r_iq_rptr] : '0;
  assign o_resp_valid     = !w_rq_empty;
  assign o_resp_data      = o_resp_valid ? r_rq_data[r_rq_rptr] : '0;
  assign o_resp_err       = o_resp_valid && r_rq_err[r_rq_rptr];
  assign o_busy           = !w_iq_empty || (r_state != S_IDLE) || !w_rq_empty;
  assign o_iq_count       = r_iq_cnt;

endmodule
`default_nettype wire
